uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of queued bytes (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset; reset is synchronous and active-high.
REQ-004 The block SHALL have port baud_div, input, 16 bits, giving the bit period minus one, in clk cycles.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning a byte is offered.
REQ-006 The block SHALL have port data_in, input, 8 bits, the offered byte.
REQ-007 The block SHALL have port in_ready, output, 1 bit, high when the FIFO is not full.
REQ-008 The block SHALL have port tx, output, 1 bit, the serial line, idle high.
REQ-009 The block SHALL have port busy, output, 1 bit, high while a frame is on the line or the FIFO is non-empty.

Function
REQ-010 A byte SHALL be accepted on any edge where in_valid && in_ready; there is no combinational path from in_valid to in_ready.
REQ-011 The frame format SHALL be 8N1: one start bit (0), data[0] through data[7] LSB first, then one stop bit (1).
REQ-012 Each bit SHALL last exactly baud_div+1 clk cycles; baud_div=0 gives 1 cycle per bit, and 0xFFFF gives 65536.
REQ-013 baud_div SHALL be latched at frame start; changes mid-frame take effect at the next frame only.
REQ-014 The FSM states SHALL be IDLE, START, DATA, and STOP.
- IDLE -> START: on the edge where the FIFO is non-empty, pop the head into the shift register.
- START -> DATA: after one bit period.
- DATA -> STOP: after 8 bit periods; the 3-bit bit index wraps 7->0.
- STOP -> START: if the FIFO is non-empty at stop end, pop back-to-back with no idle gap.
- STOP -> IDLE: otherwise.
REQ-015 Latency: a byte accepted at edge N into an empty, idle block SHALL drive tx low from edge N+2.
REQ-016 tx SHALL be registered, glitch-free, and high in IDLE.
REQ-017 A simultaneous push and pop on a full FIFO SHALL NOT be possible, because in_ready is low; on a non-full FIFO, a simultaneous push and pop SHALL leave the count unchanged.
REQ-018 The FIFO count SHALL use clog2(FIFO_DEPTH)+1 bits, and the pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 A push while the FIFO is full SHALL be ignored; the data is dropped and the FIFO is not corrupted.

Reset
REQ-020 On rst, the block SHALL force tx=1, busy=0, in_ready=1, state=IDLE, FIFO empty, and counters to 0.
REQ-021 An rst mid-frame SHALL abort the frame immediately, with tx high on the following cycle, and discard all queued bytes.
REQ-022 While rst is high, in_valid SHALL be ignored.

Structure
REQ-023 Shared package uart_pkg SHALL hold the FSM state enum, UART_DATA_BITS=8, and UART_DIV_W=16, for reuse by the receiver.
REQ-024 The FIFO SHALL be a separate sub-module, uart_sync_fifo, with parameters WIDTH and DEPTH, synchronous reset, and push/pop/full/empty/count ports.
REQ-025 The bit-period counter and the shift register SHALL reside in the top module.

Verification
REQ-026 With baud_div=3, push 0xA5 -> tx low at edge N+2; the line reads 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles; busy falls after the stop bit.
REQ-027 With baud_div=0, push 0x00, 0xFF, 0x3C back-to-back -> 30 consecutive 1-cycle bits with no idle between frames.
REQ-028 With FIFO_DEPTH=4 and one frame in flight, push 5 more bytes while transmitting -> in_ready drops after the 4th queued byte; the 5th is held until a pop, and all bytes emerge in order.
REQ-029 Change baud_div from 3 to 7 during the DATA state -> the current frame keeps 4-cycle bits, and the next frame uses 8-cycle bits.
REQ-030 Assert rst for 1 cycle during bit 4 with 2 bytes queued -> tx=1, busy=0, in_ready=1 the next cycle, and no further frames follow.
REQ-031 With baud_div=0xFFFF, push 0x01 -> the start bit lasts exactly 65536 cycles, with no counter overflow.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
// Holds the frame geometry and the line-state encoding.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;
   localparam int UART_DIV_W     = 16;
   localparam int UART_IDX_W     = $clog2(UART_DATA_BITS);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with synchronous reset and occupancy count.
// Pushes while full and pops while empty are ignored.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push = push && !full;
   assign w_pop  = pop && !empty;
   assign full   = (r_count == FULL_CNT);
   assign empty  = (r_count == '0);
   assign count  = r_count;
   assign rdata  = r_mem[r_rptr];

   // Storage is write-only on push; contents need no reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= wdata;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_ONE;
         if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
         if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
         else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter with a per-frame latched bit period.
// tx lags the FSM by one register so every bit keeps its full width.
import uart_pkg::*;

module uart_tx_fifo #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [UART_DIV_W-1:0]     baud_div,
   input  logic                      in_valid,
   input  logic [UART_DATA_BITS-1:0] data_in,
   output logic                      in_ready,
   output logic                      tx,
   output logic                      busy
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [UART_DIV_W-1:0] CNT_ONE  = UART_DIV_W'(1);
   localparam logic [UART_IDX_W-1:0] IDX_ONE  = UART_IDX_W'(1);
   localparam logic [UART_IDX_W-1:0] LAST_IDX = UART_IDX_W'(UART_DATA_BITS - 1);

   uart_state_e               r_state;
   logic [UART_DIV_W-1:0]     r_div;
   logic [UART_DIV_W-1:0]     r_cnt;
   logic [UART_DATA_BITS-1:0] r_shift;
   logic [UART_IDX_W-1:0]     r_idx;
   logic                      r_tx;
   logic                      r_act;

   logic [UART_DATA_BITS-1:0] w_head;
   logic                      w_full;
   logic                      w_empty;
   logic [CW-1:0]             w_count;
   logic                      w_push;
   logic                      w_pop;
   logic                      w_bit_end;
   logic                      w_line;

   assign w_push    = in_valid && !w_full;
   assign w_bit_end = (r_cnt == r_div);
   assign w_pop     = !w_empty &&
                      ((r_state == IDLE) ||
                       ((r_state == STOP) && w_bit_end));

   assign in_ready = !w_full;
   assign tx       = r_tx;
   assign busy     = r_act || (w_count != 0);

   uart_sync_fifo #(
      .WIDTH (UART_DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .wdata (data_in),
      .pop   (w_pop),
      .rdata (w_head),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

   // Line level implied by the current state, before the output register.
   always_comb begin
      w_line = 1'b1;
      case (r_state)
         START:   w_line = 1'b0;
         DATA:    w_line = r_shift[0];
         default: w_line = 1'b1;
      endcase
   end

   // Frame sequencer: bit timing, shifting and back-to-back pops.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_div   <= '0;
         r_cnt   <= '0;
         r_shift <= '0;
         r_idx   <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_state <= START;
                  r_shift <= w_head;
                  r_div   <= baud_div;
                  r_cnt   <= '0;
               end
            end
            START: begin
               if (w_bit_end) begin
                  r_cnt   <= '0;
                  r_idx   <= '0;
                  r_state <= DATA;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            DATA: begin
               if (w_bit_end) begin
                  r_cnt   <= '0;
                  r_shift <= {1'b0, r_shift[UART_DATA_BITS-1:1]};
                  r_idx   <= r_idx + IDX_ONE;
                  if (r_idx == LAST_IDX) r_state <= STOP;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            STOP: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (w_pop) begin
                     r_state <= START;
                     r_shift <= w_head;
                     r_div   <= baud_div;
                  end else begin
                     r_state <= IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
         endcase
      end
   end

   // Registered line and activity flag, both one cycle behind the FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx  <= 1'b1;
         r_act <= 1'b0;
      end else begin
         r_tx  <= w_line;
         r_act <= (r_state != IDLE) || !w_empty;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo against a frame-level line model.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_uart_tx_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] baud_div;
   logic        in_valid;
   logic [7:0]  data_in;
   logic        in_ready;
   logic        tx;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

   bit exp_q[$];
   bit cap_q[$];
   bit capb_q[$];

   uart_tx_fifo #(.FIFO_DEPTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .baud_div (baud_div),
      .in_valid (in_valid),
      .data_in  (data_in),
      .in_ready (in_ready),
      .tx       (tx),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Expected line: start 0, eight data bits LSB first, stop 1.
   function automatic void add_frame(input logic [7:0] b, input int div);
      bit v;
      for (int k = 0; k < 10; k++) begin
         if (k == 0)      v = 1'b0;
         else if (k == 9) v = 1'b1;
         else             v = b[k-1];
         for (int r = 0; r <= div; r++) exp_q.push_back(v);
      end
   endfunction

   task automatic capture(input int n, input int tmo, output bit ok);
      int w;
      w = 0;
      cap_q.delete();
      capb_q.delete();
      while (tx !== 1'b0 && w < tmo) begin
         @(negedge clk);
         w++;
      end
      ok = (tx === 1'b0);
      if (ok) begin
         for (int i = 0; i < n; i++) begin
            cap_q.push_back(tx);
            capb_q.push_back(busy);
            @(negedge clk);
         end
      end
   endtask

   task automatic push_byte(input logic [7:0] b, input int tmo,
                            output bit ok, output int waited);
      in_valid = 1'b1;
      data_in  = b;
      waited   = 0;
      while (in_ready !== 1'b1 && waited < tmo) begin
         @(negedge clk);
         waited++;
      end
      ok = (in_ready === 1'b1);
      if (!ok) in_valid = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      in_valid = 1'b1;
      data_in  = 8'($urandom);
      repeat (3) @(negedge clk);
      n_vec++;
      if (tx !== 1'b1) begin
         n_err++;
         $display("FAIL rst_tx got %0b want 1", tx);
      end
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL rst_busy got %0b want 0", busy);
      end
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL rst_ready got %0b want 1", in_ready);
      end
      rst      = 1'b0;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL rst_ignored_busy got %0b want 0", busy);
      end
      n_vec++;
      if (tx !== 1'b1) begin
         n_err++;
         $display("FAIL rst_ignored_tx got %0b want 1", tx);
      end
   endtask

   task automatic test_single();
      bit ok;
      do_reset();
      baud_div = 16'd3;
      exp_q.delete();
      add_frame(8'hA5, 3);
      in_valid = 1'b1;
      data_in  = 8'hA5;
      @(negedge clk);
      in_valid = 1'b0;
      n_vec++;
      if (tx !== 1'b1) begin
         n_err++;
         $display("FAIL lat_n0 tx=%0b want 1", tx);
      end
      @(negedge clk);
      n_vec++;
      if (tx !== 1'b1) begin
         n_err++;
         $display("FAIL lat_n1 tx=%0b want 1", tx);
      end
      @(negedge clk);
      n_vec++;
      if (tx !== 1'b0) begin
         n_err++;
         $display("FAIL lat_n2 tx=%0b want 0", tx);
      end
      capture(40, 0, ok);
      n_vec++;
      if (!ok || cap_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL single_len got %0d want %0d", cap_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (cap_q[i] !== exp_q[i] || capb_q[i] !== 1'b1) begin
               n_err++;
               $display("FAIL single_wave[%0d] tx=%0b busy=%0b want tx=%0b busy=1",
                        i, cap_q[i], capb_q[i], exp_q[i]);
            end
         end
      end
      n_vec++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL single_end tx=%0b busy=%0b want tx=1 busy=0", tx, busy);
      end
   endtask

   task automatic test_back_to_back();
      bit         ok;
      bit         pok;
      int         w;
      logic [7:0] bytes [3];
      bytes[0] = 8'h00;
      bytes[1] = 8'hFF;
      bytes[2] = 8'h3C;
      do_reset();
      baud_div = 16'd0;
      exp_q.delete();
      for (int j = 0; j < 3; j++) add_frame(bytes[j], 0);
      fork
         capture(30, 20, ok);
         begin
            for (int j = 0; j < 3; j++) begin
               push_byte(bytes[j], 10, pok, w);
               n_vec++;
               if (!pok || w != 0) begin
                  n_err++;
                  $display("FAIL b2b_push%0d ok=%0b wait=%0d want ok=1 wait=0", j, pok, w);
               end
            end
         end
      join
      n_vec++;
      if (!ok || cap_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL b2b_len got %0d want %0d", cap_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (cap_q[i] !== exp_q[i]) begin
               n_err++;
               $display("FAIL b2b_wave[%0d] tx=%0b want %0b", i, cap_q[i], exp_q[i]);
            end
         end
      end
      n_vec++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_end tx=%0b busy=%0b want tx=1 busy=0", tx, busy);
      end
   endtask

   task automatic test_fifo_full();
      bit         ok;
      bit         pok;
      int         w;
      int         tw;
      logic [7:0] b [6];
      do_reset();
      baud_div = 16'd1;
      exp_q.delete();
      for (int j = 0; j < 6; j++) b[j] = 8'($urandom);
      fork
         capture(120, 50, ok);
         begin
            push_byte(b[0], 10, pok, w);
            add_frame(b[0], 1);
            tw = 0;
            while (tx !== 1'b0 && tw < 20) begin
               @(negedge clk);
               tw++;
            end
            for (int j = 1; j < 5; j++) begin
               n_vec++;
               if (in_ready !== 1'b1) begin
                  n_err++;
                  $display("FAIL full_ready_before%0d got %0b want 1", j, in_ready);
               end
               push_byte(b[j], 10, pok, w);
               if (pok) add_frame(b[j], 1);
            end
            n_vec++;
            if (in_ready !== 1'b0) begin
               n_err++;
               $display("FAIL full_ready_after4 got %0b want 0", in_ready);
            end
            push_byte(b[5], 100, pok, w);
            n_vec++;
            if (!pok || w == 0) begin
               n_err++;
               $display("FAIL full_held5 ok=%0b wait=%0d want ok=1 wait>0", pok, w);
            end
            if (pok) add_frame(b[5], 1);
         end
      join
      n_vec++;
      if (!ok || cap_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL full_len got %0d want %0d", cap_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (cap_q[i] !== exp_q[i]) begin
               n_err++;
               $display("FAIL full_wave[%0d] tx=%0b want %0b", i, cap_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_baud_change();
      bit         ok;
      bit         pok;
      int         w;
      int         tw;
      logic [7:0] b0;
      logic [7:0] b1;
      do_reset();
      baud_div = 16'd3;
      exp_q.delete();
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      fork
         capture(120, 20, ok);
         begin
            push_byte(b0, 10, pok, w);
            add_frame(b0, 3);
            push_byte(b1, 10, pok, w);
            add_frame(b1, 7);
            tw = 0;
            while (tx !== 1'b0 && tw < 20) begin
               @(negedge clk);
               tw++;
            end
            repeat (8) @(negedge clk);
            baud_div = 16'd7;
         end
      join
      n_vec++;
      if (!ok || cap_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL baud_len got %0d want %0d", cap_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (cap_q[i] !== exp_q[i]) begin
               n_err++;
               $display("FAIL baud_wave[%0d] tx=%0b want %0b", i, cap_q[i], exp_q[i]);
            end
         end
      end
      n_vec++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL baud_end tx=%0b busy=%0b want tx=1 busy=0", tx, busy);
      end
   endtask

   task automatic test_random();
      bit         ok;
      bit         pok;
      int         w;
      int         div;
      logic [7:0] b;
      do_reset();
      div      = int'($urandom_range(1, 3));
      baud_div = 16'(div);
      exp_q.delete();
      fork
         capture(80 * (div + 1), 20, ok);
         begin
            for (int j = 0; j < 8; j++) begin
               b = 8'($urandom);
               push_byte(b, 200, pok, w);
               n_vec++;
               if (!pok) begin
                  n_err++;
                  $display("FAIL rand_push%0d ok=%0b want 1", j, pok);
               end else begin
                  add_frame(b, div);
               end
               repeat ($urandom_range(0, 3)) @(negedge clk);
            end
         end
      join
      n_vec++;
      if (!ok || cap_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL rand_len got %0d want %0d", cap_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (cap_q[i] !== exp_q[i]) begin
               n_err++;
               $display("FAIL rand_wave[%0d] tx=%0b want %0b", i, cap_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      bit pok;
      int w;
      int tw;
      int bad;
      do_reset();
      baud_div = 16'd3;
      for (int j = 0; j < 3; j++) push_byte(8'($urandom), 10, pok, w);
      tw = 0;
      while (tx !== 1'b0 && tw < 20) begin
         @(negedge clk);
         tw++;
      end
      n_vec++;
      if (tx !== 1'b0) begin
         n_err++;
         $display("FAIL mid_start tx=%0b want 0", tx);
      end
      repeat (21) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_vec++;
      if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL mid_abort tx=%0b busy=%0b ready=%0b want 1 0 1",
                  tx, busy, in_ready);
      end
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      n_vec++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL mid_quiet active_cycles=%0d want 0", bad);
      end
   endtask

   task automatic test_slow();
      bit pok;
      int w;
      int tw;
      int cnt;
      do_reset();
      baud_div = 16'hFFFF;
      push_byte(8'h01, 10, pok, w);
      tw = 0;
      while (tx !== 1'b0 && tw < 10) begin
         @(negedge clk);
         tw++;
      end
      cnt = 0;
      while (tx === 1'b0 && cnt < 70000) begin
         cnt++;
         @(negedge clk);
      end
      n_vec++;
      if (cnt != 65536 || tx !== 1'b1) begin
         n_err++;
         $display("FAIL slow_start low_cycles=%0d tx=%0b want 65536 then 1", cnt, tx);
      end
      do_reset();
   endtask

   initial begin
      rst      = 1'b1;
      baud_div = 16'd3;
      in_valid = 1'b0;
      data_in  = 8'h00;
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_fifo_full();
      test_baud_change();
      test_random();
      test_reset_mid();
      test_slow();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
